// File: rtl/riscv_ctrl_pkg.sv
// Package: riscv_ctrl_pkg
// Shared encodings for the multicycle RISC-V control unit.
//   - state_t      : main FSM states
//   - OP_*         : supported opcode constants (Instr[6:0])
//   - IMM_*        : ImmSrc encodings (immediate extender select)
//   - SRCA_*/SRCB_*: ALU operand mux selects
//   - RES_*        : ResultSrc encodings
//   - ALU_*        : ALUControl encodings
//   - ALUOP_*      : ALUOp encodings consumed by alu_decoder
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Module: alu_decoder
// Combinational ALU operation decoder.
// Ports:
//   i_alu_op      in  2  00=add, 01=sub, 10=decode from funct fields
//   i_funct3      in  3  Instr[14:12]
//   i_funct7b5    in  1  Instr[30]
//   i_op5         in  1  opcode[5]; 1 for R-type, 0 for I-type ALU
//   o_alu_control out 3  ALU operation select
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  // Instr[30] only selects subtract for R-type; for I-type ALU (addi)
  // that bit belongs to the immediate and must be ignored.
  logic w_rtype_sub;
  assign w_rtype_sub = i_op5 & i_funct7b5;

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = w_rtype_sub ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Module: multicycle_controller
// Main control FSM for a multicycle RISC-V core (lw, sw, R-type, I-type ALU,
// optionally beq). Each state lasts one cycle; outputs are decoded from the
// state register, with BEQ's PCWrite additionally qualified by the zero flag.
// Build option:
//   RISCV_MC_BRANCH_EN  when defined, beq is supported (BEQ state, ImmSrc=B
//                       in DECODE); otherwise beq decodes as illegal.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   opcode, funct3, funct7b5        instruction fields from the IR
//   zero                            ALU zero flag
//   ImmSrc, ALUSrcA, ALUSrcB        datapath selects
//   ALUControl, ResultSrc, AdrSrc   datapath selects
//   IRWrite, MemWrite, RegWrite,    write/load strobes
//   PCWrite
//   illegal_op                      pulse in DECODE for unsupported opcodes
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       illegal_op
);

  state_t r_state;

  logic       w_is_mem;
  logic       w_is_sw;
  logic       w_is_rtype;
  logic       w_is_itype;
  logic       w_is_branch;
  logic       w_legal;
  logic [1:0] w_alu_op;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_pcwrite;
  logic       w_illegal;

  // Opcode classification
  assign w_is_sw    = (opcode == OP_SW);
  assign w_is_mem   = (opcode == OP_LW) || w_is_sw;
  assign w_is_rtype = (opcode == OP_RTYPE);
  assign w_is_itype = (opcode == OP_ITYPE);
`ifdef RISCV_MC_BRANCH_EN
  assign w_is_branch = (opcode == OP_BEQ);
`else
  assign w_is_branch = 1'b0;
`endif
  assign w_legal = w_is_mem || w_is_rtype || w_is_itype || w_is_branch;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_mem)         r_state <= S_MEMADR;
          else if (w_is_rtype)  r_state <= S_EXECR;
          else if (w_is_itype)  r_state <= S_EXECI;
          else if (w_is_branch) r_state <= S_BEQ;
          else                  r_state <= S_FETCH;
        end
        S_MEMADR:   r_state <= w_is_sw ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_EXECR:    r_state <= S_ALUWB;
        S_EXECI:    r_state <= S_ALUWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: r_state <= S_FETCH;
        S_ALUWB:    r_state <= S_FETCH;
        S_BEQ:      r_state <= S_FETCH;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode; everything not driven by a state stays at zero.
  always_comb begin
    ImmSrc     = IMM_I;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    w_alu_op   = ALUOP_ADD;
    ResultSrc  = RES_ALUOUT;
    AdrSrc     = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_pcwrite  = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
      end
      S_DECODE: begin
        // The ALU precomputes the branch target here so BEQ only has to
        // compare; without branch support the immediate select stays at I.
`ifdef RISCV_MC_BRANCH_EN
        ImmSrc    = IMM_B;
`else
        ImmSrc    = IMM_I;
`endif
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        w_illegal = !w_legal;
      end
      S_MEMADR: begin
        ImmSrc  = w_is_sw ? IMM_S : IMM_I;
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        w_regwrite = 1'b1;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA  = SRCA_RD1;
        w_alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
      end
      S_BEQ: begin
        ALUSrcA   = SRCA_RD1;
        w_alu_op  = ALUOP_SUB;
        w_pcwrite = zero;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_op5         (opcode[5]),
    .o_alu_control (ALUControl)
  );

  // Strobes are gated by rst_n so they drop immediately on reset assertion,
  // even though FETCH (the reset state) would otherwise raise IRWrite/PCWrite.
  assign IRWrite    = w_irwrite  & rst_n;
  assign MemWrite   = w_memwrite & rst_n;
  assign RegWrite   = w_regwrite & rst_n;
  assign PCWrite    = w_pcwrite  & rst_n;
  assign illegal_op = w_illegal  & rst_n;

endmodule
